// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter (rfarb_pkg).
// The optional clear sequencer is enabled by defining RFARB_CLEAR_EN.
package rfarb_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } rfarb_state_e;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: the requester that was not granted last wins a
// conflict; a lone requester always wins. The last_grant register lives in the caller.
module rr_arbiter2
  import rfarb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_idx
);

  always_comb begin
    gnt_valid = req_a | req_b;
    gnt_idx   = GNT_A;
    if (req_a && req_b) begin
      gnt_idx = (last_grant == GNT_A) ? GNT_B : GNT_A;
    end else if (req_b) begin
      gnt_idx = GNT_B;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Write-port arbiter for the 8x8 lab register file, with an optional clear
// sequencer built when RFARB_CLEAR_EN is defined. All outputs are registered.
module rf_write_arbiter
  import rfarb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              ack_b,
`ifdef RFARB_CLEAR_EN
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
`endif
  output logic              rf_we_n,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [1:0]        fsm_state
);

  // Handshake: a requester holds req/addr/data until it sees its ack pulse.
  // ack marks the cycle its write is on the port; req still high in that
  // cycle is a fresh request, so one write per cycle is sustainable.

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_WRITE = WRITE;
`ifdef RFARB_CLEAR_EN
  localparam logic [1:0] S_CLEAR = CLEAR;
  localparam logic [ADDR_W:0] CNT_END  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
`endif

  logic [1:0] state;
  logic       last_grant;
  logic       gnt_valid;
  logic       gnt_idx;

`ifdef RFARB_CLEAR_EN
  // Holds the next address to clear; one bit wider so it stops at DEPTH.
  logic [ADDR_W:0] clr_cnt;
`endif

  assign fsm_state = state;

  rr_arbiter2 u_rr (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      last_grant <= GNT_B;
      rf_we_n    <= 1'b1;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
`ifdef RFARB_CLEAR_EN
      busy       <= 1'b0;
      clr_done   <= 1'b0;
      clr_cnt    <= '0;
`endif
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
`ifdef RFARB_CLEAR_EN
      clr_done <= 1'b0;
`endif
      case (state)
`ifdef RFARB_CLEAR_EN
        S_CLEAR: begin
          // Requests wait here; clr_req is ignored until the sweep ends.
          if (clr_cnt == CNT_END) begin
            state   <= S_IDLE;
            rf_we_n <= 1'b1;
            busy    <= 1'b0;
          end else begin
            rf_we_n  <= 1'b0;
            rf_waddr <= clr_cnt[ADDR_W-1:0];
            rf_wdata <= '0;
            clr_done <= (clr_cnt == CNT_LAST);
            clr_cnt  <= clr_cnt + 1'b1;
          end
        end
`endif
        default: begin
`ifdef RFARB_CLEAR_EN
          if (clr_req) begin
            state    <= S_CLEAR;
            busy     <= 1'b1;
            rf_we_n  <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            clr_done <= (DEPTH == 1);
            clr_cnt  <= (ADDR_W+1)'(1);
          end else
`endif
          if (gnt_valid) begin
            state      <= S_WRITE;
            rf_we_n    <= 1'b0;
            rf_waddr   <= (gnt_idx == GNT_A) ? addr_a : addr_b;
            rf_wdata   <= (gnt_idx == GNT_A) ? data_a : data_b;
            ack_a      <= (gnt_idx == GNT_A);
            ack_b      <= (gnt_idx == GNT_B);
            last_grant <= gnt_idx;
          end else begin
            state   <= S_IDLE;
            rf_we_n <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected writes are queued as stimulus
// is driven and checked against the write port as they appear.
module tb_rf_write_arbiter;
  import rfarb_pkg::*;

  `define CHK(tag, obs, exp) \
    begin \
      total++; \
      assert ((obs) === (exp)) else begin \
        bad++; \
        $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp); \
      end \
    end

  localparam logic [1:0] SRC_A = 2'd0;
  localparam logic [1:0] SRC_B = 2'd1;
  localparam logic [1:0] SRC_C = 2'd2;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a, req_b;
  logic [2:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;
  logic       ack_a, ack_b;
`ifdef RFARB_CLEAR_EN
  logic       clr_req;
  logic       busy;
  logic       clr_done;
`endif
  logic       rf_we_n;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [1:0] fsm_state;

  int total = 0;
  int bad   = 0;

  logic [12:0] exp_q[$];
  logic [7:0]  rf_mem[8] = '{default: 8'h00};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  rf_write_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .addr_a    (addr_a),
    .data_a    (data_a),
    .ack_a     (ack_a),
    .req_b     (req_b),
    .addr_b    (addr_b),
    .data_b    (data_b),
    .ack_b     (ack_b),
`ifdef RFARB_CLEAR_EN
    .clr_req   (clr_req),
    .busy      (busy),
    .clr_done  (clr_done),
`endif
    .rf_we_n   (rf_we_n),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .fsm_state (fsm_state)
  );

  // Register file model: not reset, captures on the rising edge.
  always @(posedge clk) begin
    if (!rf_we_n) rf_mem[rf_waddr] <= rf_wdata;
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [12:0] e;
    if (reset === 1'b1) begin
      `CHK("ack_exclusive", ack_a & ack_b, 1'b0)
      if (rf_we_n === 1'b0) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_write obs=%0h exp=none", rf_waddr);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          `CHK("waddr", rf_waddr, e[10:8])
          `CHK("wdata", rf_wdata, e[7:0])
          `CHK("ack_a", ack_a, (e[12:11] == SRC_A))
          `CHK("ack_b", ack_b, (e[12:11] == SRC_B))
`ifdef RFARB_CLEAR_EN
          `CHK("busy", busy, (e[12:11] == SRC_C))
          `CHK("clr_done", clr_done, (e[12:11] == SRC_C && e[10:8] == 3'd7))
`endif
        end
      end else begin
        `CHK("idle_ack_a", ack_a, 1'b0)
        `CHK("idle_ack_b", ack_b, 1'b0)
`ifdef RFARB_CLEAR_EN
        `CHK("idle_busy", busy, 1'b0)
        `CHK("idle_clr_done", clr_done, 1'b0)
`endif
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic drive_a(input logic [2:0] ad, input logic [7:0] d, input int n,
                         input bit incr, output int cyc);
    int got = 0;
    cyc = 0;
    addr_a = ad; data_a = d; req_a = 1'b1;
    while (got < n && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (ack_a === 1'b1) begin
        got++;
        if (incr) begin addr_a = addr_a + 3'd1; data_a = data_a + 8'd1; end
      end
    end
    req_a = 1'b0;
    `CHK("a_acks", got, n)
  endtask

  task automatic drive_b(input logic [2:0] ad, input logic [7:0] d, input int n,
                         input bit incr, output int cyc);
    int got = 0;
    cyc = 0;
    addr_b = ad; data_b = d; req_b = 1'b1;
    while (got < n && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (ack_b === 1'b1) begin
        got++;
        if (incr) begin addr_b = addr_b + 3'd1; data_b = data_b + 8'd1; end
      end
    end
    req_b = 1'b0;
    `CHK("b_acks", got, n)
  endtask

  function automatic logic [12:0] ent(input logic [1:0] src, input logic [2:0] ad,
                                      input logic [7:0] d);
    return {src, ad, d};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int cyc_a, cyc_b;
    reset = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
`ifdef RFARB_CLEAR_EN
    clr_req = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    `CHK("rst_we_n", rf_we_n, 1'b1)
    `CHK("rst_waddr", rf_waddr, 3'd0)
    `CHK("rst_wdata", rf_wdata, 8'd0)
    `CHK("rst_ack_a", ack_a, 1'b0)
    `CHK("rst_ack_b", ack_b, 1'b0)
    `CHK("rst_state", fsm_state, 2'(IDLE))
`ifdef RFARB_CLEAR_EN
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_clr_done", clr_done, 1'b0)
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Single write from A.
    exp_q.push_back(ent(SRC_A, 3'd3, 8'h5A));
    drive_a(3'd3, 8'h5A, 1, 1'b0, cyc_a);
    `CHK("a_single_latency", cyc_a, 1)
    repeat (2) @(negedge clk);
    `CHK("rd_reg3", rf_mem[3], 8'h5A)

    // B back-to-back, regs 4..7, no bubble.
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(SRC_B, 3'(4 + i), 8'(8'h40 + i)));
    drive_b(3'd4, 8'h40, 4, 1'b1, cyc_b);
    `CHK("b_burst_cycles", cyc_b, 4)
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) `CHK("rd_burst", rf_mem[4 + i], 8'(8'h40 + i))

    // Both held: last grant was B, so A, B, A, B.
    exp_q.push_back(ent(SRC_A, 3'd1, 8'h11));
    exp_q.push_back(ent(SRC_B, 3'd2, 8'h22));
    exp_q.push_back(ent(SRC_A, 3'd1, 8'h11));
    exp_q.push_back(ent(SRC_B, 3'd2, 8'h22));
    fork
      drive_a(3'd1, 8'h11, 2, 1'b0, cyc_a);
      drive_b(3'd2, 8'h22, 2, 1'b0, cyc_b);
    join
    `CHK("rr_cycles_b", cyc_b, 4)
    repeat (2) @(negedge clk);
    `CHK("rd_reg1", rf_mem[1], 8'h11)
    `CHK("rd_reg2", rf_mem[2], 8'h22)

`ifdef RFARB_CLEAR_EN
    begin
      int busy_cnt;
      exp_q.push_back(ent(SRC_A, 3'd0, 8'h99));
      drive_a(3'd0, 8'h99, 1, 1'b0, cyc_a);
      repeat (2) @(negedge clk);
      `CHK("rd_reg0", rf_mem[0], 8'h99)

      // Clear; clr_req held 3 cycles must not restart the sweep.
      for (int i = 0; i < 8; i++) exp_q.push_back(ent(SRC_C, 3'(i), 8'h00));
      busy_cnt = 0;
      clr_req = 1'b1;
      for (int i = 0; i < 14; i++) begin
        @(negedge clk);
        if (i == 2) clr_req = 1'b0;
        if (busy === 1'b1) busy_cnt++;
      end
      `CHK("busy_cycles", busy_cnt, 8)
      for (int i = 0; i < 8; i++) `CHK("rd_cleared", rf_mem[i], 8'h00)

      // Clear beats a simultaneous request from A.
      for (int i = 0; i < 8; i++) exp_q.push_back(ent(SRC_C, 3'(i), 8'h00));
      exp_q.push_back(ent(SRC_A, 3'd5, 8'h77));
      clr_req = 1'b1;
      fork
        drive_a(3'd5, 8'h77, 1, 1'b0, cyc_a);
        begin @(negedge clk); clr_req = 1'b0; end
      join
      `CHK("ack_after_clear_latency", cyc_a, 10)
      repeat (2) @(negedge clk);
      `CHK("rd_reg5", rf_mem[5], 8'h77)

      // Reload all registers, then abort a clear at its 4th write.
      for (int i = 0; i < 8; i++) exp_q.push_back(ent(SRC_B, 3'(i), 8'(8'hA0 + i)));
      drive_b(3'd0, 8'hA0, 8, 1'b1, cyc_b);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) exp_q.push_back(ent(SRC_C, 3'(i), 8'h00));
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      `CHK("abort_we_n", rf_we_n, 1'b1)
      `CHK("abort_waddr", rf_waddr, 3'd0)
      `CHK("abort_wdata", rf_wdata, 8'd0)
      `CHK("abort_busy", busy, 1'b0)
      `CHK("abort_clr_done", clr_done, 1'b0)
      `CHK("abort_state", fsm_state, 2'(IDLE))
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      `CHK("post_abort_busy", busy, 1'b0)
      `CHK("post_abort_we_n", rf_we_n, 1'b1)
      for (int i = 0; i < 3; i++) `CHK("rd_abort_zero", rf_mem[i], 8'h00)
      for (int i = 3; i < 8; i++) `CHK("rd_abort_kept", rf_mem[i], 8'(8'hA0 + i))
    end
`endif

    repeat (2) @(negedge clk);
    `CHK("queue_drained", exp_q.size(), 0)
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
